// File: rtl/mix_output_controller_pkg.sv
// Shared dimensions and global state codes for the mixer return path.
// Dimensions are package constants so every file and the bench agree on them.
package mix_output_controller_pkg;

  localparam int HID_DIM     = 4;
  localparam int N_LEN       = 8;
  localparam int STATE_LEN   = 3;
  localparam int ROW_CNT_LEN = $clog2(HID_DIM);
  localparam int ROW_W       = HID_DIM * N_LEN;
  localparam int MAT_W       = HID_DIM * HID_DIM * N_LEN;

  localparam logic [STATE_LEN-1:0] MIX1 = 3'd2;
  localparam logic [STATE_LEN-1:0] MIX2 = 3'd3;
  localparam logic [STATE_LEN-1:0] MIX3 = 3'd4;

  function automatic logic isMixState(input logic [STATE_LEN-1:0] s);
    return (s == MIX1) || (s == MIX2) || (s == MIX3);
  endfunction

endpackage

// File: rtl/mix_output_controller_row_scatter.sv
// Combinational merge of one mix-layer row into the assembly buffer,
// either as row cnt (straight) or as column cnt (transposed).
module row_scatter
  import mix_output_controller_pkg::*;
(
  input  logic [MAT_W-1:0]       i_asm_buf,
  input  logic [ROW_W-1:0]       i_d_row,
  input  logic [ROW_CNT_LEN-1:0] i_cnt,
  input  logic                   i_transpose,
  output logic [MAT_W-1:0]       o_asm_buf
);

  for (genvar i = 0; i < HID_DIM; i++) begin : g_row
    for (genvar j = 0; j < HID_DIM; j++) begin : g_col
      localparam int IDX = (HID_DIM * i + j) * N_LEN;
      logic             w_hit;
      logic [N_LEN-1:0] w_src;

      // Transposed: row element i lands in cell (i, cnt).
      assign w_hit = i_transpose ? (i_cnt == ROW_CNT_LEN'(j)) : (i_cnt == ROW_CNT_LEN'(i));
      assign w_src = i_transpose ? i_d_row[i*N_LEN +: N_LEN] : i_d_row[j*N_LEN +: N_LEN];
      assign o_asm_buf[IDX +: N_LEN] = w_hit ? w_src : i_asm_buf[IDX +: N_LEN];
    end
  end

endmodule

// File: rtl/mix_output_controller.sv
// Assembles row-serial mix results into a full matrix; returns MIX1/MIX2
// frames on d_mix and hands the MIX3 frame downstream on q_out.
module mix_output_controller
  import mix_output_controller_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [STATE_LEN-1:0] state,
  input  logic [ROW_W-1:0]     d_row,
  input  logic                 valid_row,
  output logic                 valid_mix,
  output logic [MAT_W-1:0]     d_mix,
  output logic                 valid_out,
  output logic [MAT_W-1:0]     q_out
);

  logic [STATE_LEN-1:0]   r_prevState;
  logic [ROW_CNT_LEN-1:0] r_cnt;
  logic [MAT_W-1:0]       r_asmBuf;
  logic [MAT_W-1:0]       r_dMix;
  logic [MAT_W-1:0]       r_qOut;
  logic                   r_validMix;
  logic                   r_validOut;

  logic                   w_isMix;
  logic                   w_abort;
  logic                   w_accept;
  logic                   w_last;
  logic [ROW_CNT_LEN-1:0] w_rowCnt;
  logic [MAT_W-1:0]       w_nextBuf;

  // A state change restarts the frame; a row arriving with it becomes row 0.
  assign w_isMix  = isMixState(state);
  assign w_abort  = (state != r_prevState);
  assign w_accept = valid_row && w_isMix;
  assign w_rowCnt = w_abort ? '0 : r_cnt;
  assign w_last   = w_accept && !w_abort && (r_cnt == ROW_CNT_LEN'(HID_DIM - 1));

  row_scatter u_row_scatter (
    .i_asm_buf   (r_asmBuf),
    .i_d_row     (d_row),
    .i_cnt       (w_rowCnt),
    .i_transpose (state == MIX2),
    .o_asm_buf   (w_nextBuf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prevState <= '0;
      r_cnt       <= '0;
      r_asmBuf    <= '0;
      r_dMix      <= '0;
      r_qOut      <= '0;
      r_validMix  <= 1'b0;
      r_validOut  <= 1'b0;
    end else begin
      r_prevState <= state;
      r_validMix  <= 1'b0;
      r_validOut  <= 1'b0;
      if (!w_isMix) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_asmBuf <= w_nextBuf;
        if (w_last) begin
          r_cnt <= '0;
          if (state == MIX3) begin
            r_qOut     <= w_nextBuf;
            r_validOut <= 1'b1;
          end else begin
            r_dMix     <= w_nextBuf;
            r_validMix <= 1'b1;
          end
        end else begin
          r_cnt <= w_rowCnt + ROW_CNT_LEN'(1);
        end
      end else if (w_abort) begin
        r_cnt <= '0;
      end
    end
  end

  assign valid_mix = r_validMix;
  assign d_mix     = r_dMix;
  assign valid_out = r_validOut;
  assign q_out     = r_qOut;

endmodule
